serial_subtractor: RTL and testbench

- Bit-serial binary subtractor: computes diff = A - B - b_in over WIDTH clock cycles, LSB first, with a single borrow flip-flop.
- Complements the combinational 4-bit binary_adder in the arithmetic lab datapath. Trades latency for one full-subtractor cell plus shift registers.
- Uses a start/busy/done handshake so a controller or testbench can sequence operations.

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = A - B - b_in, one bit per clock, LSB first.
// Optional two's-complement overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, a_sr_nxt;
  logic [WIDTH-1:0] b_sr, b_sr_nxt;
  logic [WIDTH-1:0] res_sr, res_sr_nxt, res_shift;
  logic [WIDTH-1:0] diff_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             br, br_nxt;
  logic             b_out_nxt, busy_nxt, done_nxt;
  logic             bit_a, bit_b, bit_d, bit_br;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_nxt;
`endif

  // Full-subtractor cell on the current LSBs
  assign bit_a     = a_sr[0];
  assign bit_b     = b_sr[0];
  assign bit_d     = bit_a ^ bit_b ^ br;
  assign bit_br    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
  assign res_shift = {bit_d, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      b_out  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      a_sr   <= a_sr_nxt;
      b_sr   <= b_sr_nxt;
      res_sr <= res_sr_nxt;
      cnt    <= cnt_nxt;
      br     <= br_nxt;
      diff   <= diff_nxt;
      b_out  <= b_out_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf    <= ovf_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    a_sr_nxt   = a_sr;
    b_sr_nxt   = b_sr;
    res_sr_nxt = res_sr;
    cnt_nxt    = cnt;
    br_nxt     = br;
    diff_nxt   = diff;
    b_out_nxt  = b_out;
    busy_nxt   = busy;
    done_nxt   = done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_nxt    = ovf;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_sr_nxt   = A;
          b_sr_nxt   = B;
          res_sr_nxt = '0;
          br_nxt     = b_in;
          cnt_nxt    = '0;
          busy_nxt   = 1'b1;
          done_nxt   = 1'b0;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_nxt   = a_sr >> 1;
        b_sr_nxt   = b_sr >> 1;
        res_sr_nxt = res_shift;
        br_nxt     = bit_br;
        cnt_nxt    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          diff_nxt  = res_shift;
          b_out_nxt = bit_br;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // On the last bit the shift registers hold the operand MSBs
          ovf_nxt   = (bit_a ^ bit_b) & (bit_d ^ bit_a);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized
// operations against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;
  localparam int LIMIT = 3 * WIDTH + 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             b_in = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             b_out, busy, done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  int passed = 0;
  int total = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .b_in(b_in),
    .diff(diff), .b_out(b_out),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: plain modular arithmetic
  function automatic logic [WIDTH-1:0] ref_diff(input int ai, input int bi, input int ci);
    int full;
    full = ai - bi - ci;
    return full[WIDTH-1:0];
  endfunction

  function automatic logic ref_borrow(input int ai, input int bi, input int ci);
    return ai < (bi + ci);
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                   input logic [WIDTH-1:0] di);
    return (ai[WIDTH-1] != bi[WIDTH-1]) && (di[WIDTH-1] != ai[WIDTH-1]);
  endfunction

  // Present operands with start for one edge; returns 1 ns after the accepting edge
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; b_in = cv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges elapsed until done, and number of samples with busy high
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = busy ? 1 : 0;
    while (!done && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({diff, b_out, busy, done} !== '0)
      $display("FAIL reset_outputs: got %h/%b/%b/%b, want 0/0/0/0", diff, b_out, busy, done);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0/0", busy, done);
    else passed++;
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] av [5] = '{4'd2, 4'd7, 4'd0, 4'd0, 4'd8};
    logic [WIDTH-1:0] bv [5] = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd8};
    logic             cv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] dv [5] = '{4'hF, 4'h3, 4'hF, 4'h0, 4'hF};
    logic             ov [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int n, bn;
    for (int i = 0; i < 5; i++) begin
      launch(av[i], bv[i], cv[i]);
      wait_done(n, bn);
      total++;
      if (n !== WIDTH || bn !== WIDTH)
        $display("FAIL directed_timing[%0d]: done after %0d edges busy %0d, want %0d/%0d",
                 i, n, bn, WIDTH, WIDTH);
      else passed++;
      total++;
      if (diff !== dv[i] || b_out !== ov[i])
        $display("FAIL directed_result[%0d]: got %h/%b, want %h/%b", i, diff, b_out, dv[i], ov[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int n, bn;
    launch(4'd7, 4'd4, 1'b0);
    wait_done(n, bn);
    total++;
    if (diff !== 4'h3 || b_out !== 1'b0)
      $display("FAIL b2b_first: got %h/%b, want 3/0", diff, b_out);
    else passed++;
    launch(4'd4, 4'd2, 1'b1);
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || diff !== 4'h3)
      $display("FAIL b2b_restart: done=%b busy=%b diff=%h, want 0/1/3", done, busy, diff);
    else passed++;
    wait_done(n, bn);
    total++;
    if (n !== WIDTH || diff !== 4'h1 || b_out !== 1'b0)
      $display("FAIL b2b_second: edges=%0d diff=%h b_out=%b, want %0d/1/0", n, diff, b_out, WIDTH);
    else passed++;
  endtask

  task automatic test_start_ignored;
    int n = 0;
    launch(4'd5, 4'd1, 1'b0);
    while (!done && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin a = 4'd9; b = 4'd9; start = 1'b1; end
      if (n == 2) start = 1'b0;
    end
    total++;
    if (n !== WIDTH || diff !== 4'h4 || b_out !== 1'b0)
      $display("FAIL start_ignored: edges=%0d diff=%h b_out=%b, want %0d/4/0", n, diff, b_out, WIDTH);
    else passed++;
    // Hold in DONE with start low
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1 || diff !== 4'h4)
      $display("FAIL done_hold: done=%b diff=%h, want 1/4", done, diff);
    else passed++;
  endtask

  task automatic test_async_reset;
    int n, bn;
    launch(4'd6, 4'd2, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({diff, b_out, busy, done} !== '0)
      $display("FAIL async_reset: got %h/%b/%b/%b, want 0/0/0/0", diff, b_out, busy, done);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 1) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle: busy=%b done=%b, want 0/0", busy, done);
    else passed++;
    launch(4'd3, 4'd1, 1'b0);
    wait_done(n, bn);
    total++;
    if (n !== WIDTH || diff !== 4'h2 || b_out !== 1'b0)
      $display("FAIL after_reset: edges=%0d diff=%h b_out=%b, want %0d/2/0", n, diff, b_out, WIDTH);
    else passed++;
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf;
    logic [WIDTH-1:0] av [3] = '{4'h8, 4'h7, 4'h3};
    logic [WIDTH-1:0] bv [3] = '{4'h1, 4'hF, 4'h1};
    logic [WIDTH-1:0] dv [3] = '{4'h7, 4'h8, 4'h2};
    logic             ov [3] = '{1'b1, 1'b1, 1'b0};
    int n, bn;
    for (int i = 0; i < 3; i++) begin
      launch(av[i], bv[i], 1'b0);
      wait_done(n, bn);
      total++;
      if (diff !== dv[i] || ovf !== ov[i])
        $display("FAIL ovf[%0d]: got diff=%h ovf=%b, want %h/%b", i, diff, ovf, dv[i], ov[i]);
      else passed++;
    end
  endtask
`endif

  task automatic test_random;
    logic [WIDTH-1:0] av, bv, ed;
    logic cv, eb;
    int n, bn;
    for (int i = 0; i < 40; i++) begin
      av = WIDTH'($urandom);
      bv = WIDTH'($urandom);
      cv = 1'($urandom);
      ed = ref_diff(int'(av), int'(bv), int'(cv));
      eb = ref_borrow(int'(av), int'(bv), int'(cv));
      launch(av, bv, cv);
      wait_done(n, bn);
      total++;
      if (n !== WIDTH || bn !== WIDTH || diff !== ed || b_out !== eb)
        $display("FAIL random[%0d] %h-%h-%b: edges=%0d busy=%0d got %h/%b, want %0d/%0d %h/%b",
                 i, av, bv, cv, n, bn, diff, b_out, WIDTH, WIDTH, ed, eb);
      else passed++;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      total++;
      if (ovf !== ref_ovf(av, bv, ed))
        $display("FAIL random_ovf[%0d]: got %b, want %b", i, ovf, ref_ovf(av, bv, ed));
      else passed++;
`endif
      // Occasionally idle between operations
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

  initial begin
    #12;
    test_reset;
    test_directed;
    test_back_to_back;
    test_start_ignored;
    test_async_reset;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf;
`endif
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
